// File: rtl/seg_scan_reader.sv
// Reader for a scanned 4-digit 7-segment bus: samples each digit once per dwell, decodes it
// to BCD, and commits a digit only after it has decoded to the same value several times in a row.
module seg_scan_reader #(
   parameter int unsigned SETTLE     = 2,
   parameter int unsigned STABLE_CNT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  seg,
   input  logic [3:0]  ssd_ctl,
   output logic [15:0] bcd,
   output logic [3:0]  dp,
   output logic [3:0]  known,
   output logic [3:0]  upd,
   output logic        err,
   output logic [1:0]  err_digit
);

   typedef enum logic [1:0] {StWait, StSample, StDone} state_e;

   // The edge that registers a new ctl value already counts as the first settle cycle
   localparam logic [3:0] SettleLoad = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   localparam state_e     EntryState = (SETTLE == 0) ? StSample : StWait;
   localparam logic [3:0] StableN    = 4'(STABLE_CNT);

   function automatic logic one_low(input logic [3:0] c);
      return (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
   endfunction

   logic [7:0]       seg_q;
   logic [3:0]       ctl_q;
   state_e           state_q, state_d;
   logic [3:0]       settle_q, settle_d;
   logic [3:0][3:0]  cand_q, cand_d;
   logic [3:0]       cdp_q, cdp_d;
   logic [3:0][3:0]  cnt_q, cnt_d;
   logic [15:0]      bcd_q, bcd_d;
   logic [3:0]       dp_q, dp_d;
   logic [3:0]       known_q, known_d;
   logic [3:0]       upd_q, upd_d;
   logic             err_q, err_d;
   logic [1:0]       err_digit_q, err_digit_d;

   logic [1:0]       idx;
   logic [3:0]       dec_val;
   logic             dec_ok;
   logic             smp_dp;

   // Dwell FSM: change detection compares the incoming enables against ctl_q
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      if (ssd_ctl != ctl_q) begin
         if (one_low(ssd_ctl)) begin
            state_d  = EntryState;
            settle_d = SettleLoad;
         end else begin
            state_d  = StDone;
            settle_d = 4'd0;
         end
      end else begin
         unique case (state_q)
            StWait: begin
               if (settle_q == 4'd0) state_d = StSample;
               else                  settle_d = settle_q - 4'd1;
            end
            StSample: state_d = StDone;
            default:  ;
         endcase
      end
   end

   always_comb begin
      idx = 2'd0;
      unique case (ctl_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   // seg_q[7:1] = {a,b,c,d,e,f,g}, active-low
   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'd0;
      case (seg_q[7:1])
         7'b0000001: dec_val = 4'd0;
         7'b1001111: dec_val = 4'd1;
         7'b0010010: dec_val = 4'd2;
         7'b0000110: dec_val = 4'd3;
         7'b1001100: dec_val = 4'd4;
         7'b0100100: dec_val = 4'd5;
         7'b0100000: dec_val = 4'd6;
         7'b0001111: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0000100: dec_val = 4'd9;
         default:    dec_ok  = 1'b0;
      endcase
   end

   assign smp_dp = ~seg_q[0];

   always_comb begin
      cand_d      = cand_q;
      cdp_d       = cdp_q;
      cnt_d       = cnt_q;
      err_d       = 1'b0;
      err_digit_d = err_digit_q;
      if (state_q == StSample) begin
         if (!dec_ok) begin
            cnt_d[idx]  = 4'd0;
            err_d       = 1'b1;
            err_digit_d = idx;
         end else if (dec_val == cand_q[idx] && smp_dp == cdp_q[idx]) begin
            if (cnt_q[idx] < StableN) cnt_d[idx] = cnt_q[idx] + 4'd1;
         end else begin
            cand_d[idx] = dec_val;
            cdp_d[idx]  = smp_dp;
            cnt_d[idx]  = 4'd1;
         end
      end
   end

   // At most one digit can newly reach the threshold per clk, so at most one commit fires
   always_comb begin
      bcd_d   = bcd_q;
      dp_d    = dp_q;
      known_d = known_q;
      upd_d   = 4'd0;
      for (int i = 0; i < 4; i++) begin
         if (cnt_q[i] == StableN &&
             (cand_q[i] != bcd_q[4*i +: 4] || cdp_q[i] != dp_q[i] || !known_q[i])) begin
            bcd_d[4*i +: 4] = cand_q[i];
            dp_d[i]         = cdp_q[i];
            known_d[i]      = 1'b1;
            upd_d[i]        = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q       <= 8'hFF;
         ctl_q       <= 4'hF;
         state_q     <= StDone;
         settle_q    <= 4'd0;
         cand_q      <= '0;
         cdp_q       <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         dp_q        <= '0;
         known_q     <= '0;
         upd_q       <= '0;
         err_q       <= 1'b0;
         err_digit_q <= 2'd0;
      end else begin
         seg_q       <= seg;
         ctl_q       <= ssd_ctl;
         state_q     <= state_d;
         settle_q    <= settle_d;
         cand_q      <= cand_d;
         cdp_q       <= cdp_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         dp_q        <= dp_d;
         known_q     <= known_d;
         upd_q       <= upd_d;
         err_q       <= err_d;
         err_digit_q <= err_digit_d;
      end
   end

   assign bcd       = bcd_q;
   assign dp        = dp_q;
   assign known     = known_q;
   assign upd       = upd_q;
   assign err       = err_q;
   assign err_digit = err_digit_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: drives scanned digit patterns, counts upd/err pulses,
// and checks committed digits with immediate assertions.
module tb_seg_scan_reader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  seg;
   logic [3:0]  ssd_ctl;
   logic [15:0] bcd;
   logic [3:0]  dp;
   logic [3:0]  known;
   logic [3:0]  upd;
   logic        err;
   logic [1:0]  err_digit;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   int upd_cnt [4];
   int err_cnt;
   int multi_upd;
   logic [1:0] last_err_digit;

   logic [6:0] pat [10];
   logic [6:0] blank;

   seg_scan_reader #(
      .SETTLE    (2),
      .STABLE_CNT(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .seg      (seg),
      .ssd_ctl  (ssd_ctl),
      .bcd      (bcd),
      .dp       (dp),
      .known    (known),
      .upd      (upd),
      .err      (err),
      .err_digit(err_digit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: looks at outputs 2 time units after each rising edge
   always begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) if (upd[i]) upd_cnt[i]++;
      if ($countones(upd) > 1) multi_upd++;
      if (err) begin
         err_cnt++;
         last_err_digit = err_digit;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) upd_cnt[i] = 0;
      err_cnt   = 0;
      multi_upd = 0;
   endtask

   task automatic dwell(input int d, input logic [6:0] p, input logic dp_on, input int n);
      logic [3:0] one;
      one     = 4'b0001 << d;
      ssd_ctl = ~one;
      seg     = {p, ~dp_on};
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] v, input logic [3:0] dpv);
      for (int i = 0; i < 4; i++) dwell(i, pat[v[4*i +: 4]], dpv[i], 8);
   endtask

   task automatic check_upd(input string tag, input int e0, input int e1, input int e2,
                            input int e3);
      check({tag, "_upd0"}, upd_cnt[0], e0);
      check({tag, "_upd1"}, upd_cnt[1], e1);
      check({tag, "_upd2"}, upd_cnt[2], e2);
      check({tag, "_upd3"}, upd_cnt[3], e3);
   endtask

   initial begin
      pat[0] = 7'b0000001; pat[1] = 7'b1001111; pat[2] = 7'b0010010; pat[3] = 7'b0000110;
      pat[4] = 7'b1001100; pat[5] = 7'b0100100; pat[6] = 7'b0100000; pat[7] = 7'b0001111;
      pat[8] = 7'b0000000; pat[9] = 7'b0000100;
      blank  = 7'b1111111;
      last_err_digit = 2'd0;
      clear_counts();

      rst_n   = 1'b0;
      ssd_ctl = 4'hF;
      seg     = 8'hFF;
      #2;
      check("rst_bcd", bcd, 16'h0);
      check("rst_dp", dp, 4'h0);
      check("rst_known", known, 4'h0);
      check("rst_upd", upd, 4'h0);
      check("rst_err", err, 1'b0);
      check("rst_err_digit", err_digit, 2'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: three scans of 4321 commit every digit exactly once
      scan(16'h4321, 4'h0);
      scan(16'h4321, 4'h0);
      check("t1_known_after2", known, 4'h0);
      check("t1_bcd_after2", bcd, 16'h0);
      scan(16'h4321, 4'h0);
      check("t1_bcd", bcd, 16'h4321);
      check("t1_known", known, 4'hF);
      check("t1_dp", dp, 4'h0);
      check_upd("t1", 1, 1, 1, 1);

      // 2: steady display, no further updates
      repeat (10) scan(16'h4321, 4'h0);
      check_upd("t2", 1, 1, 1, 1);
      check("t2_err_cnt", err_cnt, 0);
      check("t2_bcd", bcd, 16'h4321);

      // 3: digit 2 shows 9 for only two scans, then returns to 3
      repeat (2) scan(16'h4921, 4'h0);
      check("t3_bcd_mid", bcd, 16'h4321);
      repeat (3) scan(16'h4321, 4'h0);
      check("t3_bcd", bcd, 16'h4321);
      check_upd("t3", 1, 1, 1, 1);

      // 4: blank on digit 1 during one dwell
      dwell(0, pat[1], 1'b0, 8);
      dwell(1, blank, 1'b0, 8);
      dwell(2, pat[3], 1'b0, 8);
      dwell(3, pat[4], 1'b0, 8);
      check("t4_err_cnt", err_cnt, 1);
      check("t4_err_digit", last_err_digit, 2'd1);
      check("t4_bcd_after_err", bcd, 16'h4321);
      check("t4_known_after_err", known, 4'hF);
      repeat (3) scan(16'h4321, 4'h0);
      check("t4_bcd", bcd, 16'h4321);
      check_upd("t4", 1, 1, 1, 1);

      // 5: short dwell and a two-digit-enable pattern must not sample
      dwell(2, blank, 1'b0, 2);
      ssd_ctl = 4'b0011;
      seg     = 8'hFF;
      repeat (5) @(negedge clk);
      check("t5_glitch_err_cnt", err_cnt, 1);
      check("t5_glitch_bcd", bcd, 16'h4321);
      // A dwell of exactly SETTLE+1 clks is the shortest that samples
      dwell(3, blank, 1'b0, 3);
      dwell(0, pat[1], 1'b0, 8);
      check("t5_min_dwell_err_cnt", err_cnt, 2);
      check("t5_min_dwell_err_digit", last_err_digit, 2'd3);
      dwell(1, pat[2], 1'b0, 8);
      dwell(2, pat[3], 1'b0, 8);
      dwell(3, pat[4], 1'b0, 8);

      // New value with dp: commit appears on the 5th edge of the third dwell
      repeat (2) scan(16'h4328, 4'h1);
      check("cm_bcd_before", bcd, 16'h4321);
      dwell(0, pat[8], 1'b1, 4);
      check("cm_lat_early", bcd[3:0], 4'h1);
      dwell(0, pat[8], 1'b1, 1);
      check("cm_lat_digit", bcd[3:0], 4'h8);
      check("cm_lat_dp", dp, 4'h1);
      dwell(0, pat[8], 1'b1, 3);
      dwell(1, pat[2], 1'b0, 8);
      dwell(2, pat[3], 1'b0, 8);
      dwell(3, pat[4], 1'b0, 8);
      check("cm_bcd", bcd, 16'h4328);
      check_upd("cm", 2, 1, 1, 1);
      check("cm_err_cnt", err_cnt, 2);

      // 6: reset mid-scan discards partial counts
      repeat (2) scan(16'h8765, 4'h0);
      check("t6_bcd_pre", bcd, 16'h4328);
      dwell(0, pat[5], 1'b0, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_bcd", bcd, 16'h0);
      check("t6_rst_dp", dp, 4'h0);
      check("t6_rst_known", known, 4'h0);
      check("t6_rst_upd", upd, 4'h0);
      ssd_ctl = 4'hF;
      seg     = 8'hFF;
      repeat (3) @(negedge clk);
      clear_counts();
      rst_n = 1'b1;
      repeat (2) scan(16'h8765, 4'h0);
      check("t6_known_after2", known, 4'h0);
      check("t6_bcd_after2", bcd, 16'h0);
      scan(16'h8765, 4'h0);
      check("t6_bcd", bcd, 16'h8765);
      check("t6_known", known, 4'hF);
      check("t6_dp", dp, 4'h0);
      check_upd("t6", 1, 1, 1, 1);
      check("t6_err_cnt", err_cnt, 0);
      check("multi_upd", multi_upd, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
